// File: rtl/fwrisc_mds_arbiter.sv
// ---------------------------------------------------------------------------------------------
// fwrisc_mds_arbiter
//
// Shares a single fwrisc_mul_div_shift unit between two requesters and sequences it one
// operation at a time.
//
// Sequence per operation:
//   IDLE  -> pick a requester (round-robin when both ask) and latch its payload
//   ISSUE -> one-cycle mds_in_valid start pulse
//   WAIT  -> wait for mds_out_valid, or give up after TIMEOUT_CYCLES cycles
//   RESP  -> present the result to the granted requester until it takes it
//
// Ports
//   clock, reset        sole clock; asynchronous active-high reset
//   req_valid/ready[n]  per-requester request handshake (ready is combinational, IDLE only)
//   req_a/b[32n+:32]    operands for requester n
//   req_op[4n+:4]       unit op code for requester n, passed through unmodified
//   req_tag[TWn+:TW]    requester tag, echoed on rsp_tag
//   rsp_valid/ready[n]  per-requester response handshake
//   rsp_data/tag/err    shared response bus, qualified by rsp_valid
//   mds_in_a/b, mds_op  operands/op to the unit, stable from ISSUE until the op completes
//   mds_in_valid        single-cycle start pulse to the unit
//   mds_out(_valid)     unit result and completion pulse
// ---------------------------------------------------------------------------------------------
module fwrisc_mds_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TW             = 1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [63:0]       req_a,
    input  logic [63:0]       req_b,
    input  logic [7:0]        req_op,
    input  logic [2*TW-1:0]   req_tag,

    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [TW-1:0]     rsp_tag,
    output logic              rsp_err,

    output logic [31:0]       mds_in_a,
    output logic [31:0]       mds_in_b,
    output logic [3:0]        mds_op,
    output logic              mds_in_valid,
    input  logic [31:0]       mds_out,
    input  logic              mds_out_valid
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e          state;
    state_e          state_next;

    logic            grant;       // requester selected this cycle (IDLE only)
    logic            grant_q;     // requester owning the op in flight
    logic            last_grant;  // requester served most recently
    logic [CW-1:0]   counter;     // WAIT-state watchdog
    logic            req_fire;
    logic            timeout_hit;

    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [3:0]      sel_op;
    logic [TW-1:0]   sel_tag;

    // -----------------------------------------------------------------------------------------
    // Arbitration: a lone requester wins outright; when both ask, the one not served last wins.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req_valid[1] & ~req_valid[0];
        end
    end

    assign sel_a   = grant ? req_a[63:32]        : req_a[31:0];
    assign sel_b   = grant ? req_b[63:32]        : req_b[31:0];
    assign sel_op  = grant ? req_op[7:4]         : req_op[3:0];
    assign sel_tag = grant ? req_tag[2*TW-1:TW]  : req_tag[TW-1:0];

    assign req_fire    = (state == StIdle) && req_valid[grant];
    assign timeout_hit = (counter == CW'(TIMEOUT_CYCLES - 1));

    // -----------------------------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            StIdle: begin
                if (req_fire) begin
                    state_next = StIssue;
                end
            end
            StIssue: begin
                state_next = StWait;
            end
            StWait: begin
                // A real completion takes priority over a watchdog expiry in the same cycle.
                if (mds_out_valid || timeout_hit) begin
                    state_next = StResp;
                end
            end
            StResp: begin
                // Only the owning requester's ready completes the response.
                if (rsp_ready[grant_q]) begin
                    state_next = StIdle;
                end
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------------------------
    always_comb begin
        req_ready    = 2'b00;
        mds_in_valid = 1'b0;
        case (state)
            StIdle: begin
                req_ready[grant] = req_valid[grant];
            end
            StIssue: begin
                mds_in_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Datapath: operand/tag capture, watchdog, result capture and response handshake
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mds_in_a   <= '0;
            mds_in_b   <= '0;
            mds_op     <= '0;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;
            counter    <= '0;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_fire) begin
                        mds_in_a   <= sel_a;
                        mds_in_b   <= sel_b;
                        mds_op     <= sel_op;
                        rsp_tag    <= sel_tag;
                        grant_q    <= grant;
                        last_grant <= grant;
                    end
                end
                StIssue: begin
                    counter <= '0;
                end
                StWait: begin
                    if (mds_out_valid) begin
                        rsp_data           <= mds_out;
                        rsp_err            <= 1'b0;
                        rsp_valid[grant_q] <= 1'b1;
                    end else if (timeout_hit) begin
                        // Unit never answered: abandon the op and report an error.
                        rsp_data           <= '0;
                        rsp_err            <= 1'b1;
                        rsp_valid[grant_q] <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid <= 2'b00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_mds_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_fwrisc_mds_arbiter
//
// Drives fwrisc_mds_arbiter against a behavioural stub of the mul/div/shift unit. A scoreboard
// predicts every response (port, tag, data, err) from the request payload at acceptance and the
// round-robin rule; directed scenarios check handshakes, holding, timeout and reset timing.
// ---------------------------------------------------------------------------------------------
module tb_fwrisc_mds_arbiter;

    localparam int TO = 64;
    localparam int TW = 1;

    localparam logic [3:0] OP_SLL = 4'd1;
    localparam logic [3:0] OP_SRL = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;

    logic              clock;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [63:0]       req_a;
    logic [63:0]       req_b;
    logic [7:0]        req_op;
    logic [2*TW-1:0]   req_tag;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic              rsp_err;
    logic [31:0]       mds_in_a;
    logic [31:0]       mds_in_b;
    logic [3:0]        mds_op;
    logic              mds_in_valid;
    logic [31:0]       mds_out;
    logic              mds_out_valid;

    int n_tests;
    int n_fail;

    fwrisc_mds_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .TW             (TW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .req_tag       (req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err),
        .mds_in_a      (mds_in_a),
        .mds_in_b      (mds_in_b),
        .mds_op        (mds_op),
        .mds_in_valid  (mds_in_valid),
        .mds_out       (mds_out),
        .mds_out_valid (mds_out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] op_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_MUL:  return a * b;
            OP_DIV:  return (b == 0) ? 32'hffff_ffff : a / b;
            default: return a + b;
        endcase
    endfunction

    // ---------------------------------------------------------------- unit stub
    logic        stub_dead;   // when set, ops issued from now on never complete
    int          stub_lat;    // extra cycles after the start pulse before completion
    logic        stub_busy;
    int          stub_cnt;
    logic        stub_pulse;
    logic [31:0] stub_res;
    logic [31:0] stub_a;
    logic [31:0] stub_b;
    logic [3:0]  stub_op;
    logic        man_pulse;   // hand-driven completion pulse (stale-pulse scenario)
    logic [31:0] man_data;

    assign mds_out_valid = stub_pulse | man_pulse;
    assign mds_out       = stub_pulse ? stub_res : man_data;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            stub_busy  <= 1'b0;
            stub_cnt   <= 0;
            stub_pulse <= 1'b0;
            stub_res   <= '0;
        end else begin
            stub_pulse <= 1'b0;
            if (mds_in_valid) begin
                stub_busy <= !stub_dead;
                stub_cnt  <= stub_lat;
                stub_a    <= mds_in_a;
                stub_b    <= mds_in_b;
                stub_op   <= mds_op;
                stub_res  <= op_result(mds_op, mds_in_a, mds_in_b);
            end else if (stub_busy) begin
                if (stub_cnt == 0) begin
                    stub_pulse <= 1'b1;
                    stub_busy  <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        int            port;
        logic [TW-1:0] tag;
        logic [31:0]   data;
        logic          err;
    } exp_t;

    exp_t        exp_q[$];
    int          model_last;
    bit          outstanding;
    logic [1:0]  last_acc;
    int          n_accept;
    int          n_issue;

    // Sampled on the falling edge: everything seen here is what the next rising edge acts on.
    always @(negedge clock) begin
        logic [1:0] acc;
        int         ep;
        exp_t       e;
        if (reset) begin
            exp_q.delete();
            model_last  = 1;
            outstanding = 0;
            last_acc    = 2'b00;
        end else begin
            n_tests++;
            if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) begin
                n_fail++;
                $display("FAIL onehot: req_ready=%b rsp_valid=%b, required at most one bit each",
                         req_ready, rsp_valid);
            end

            acc      = req_valid & req_ready;
            last_acc = acc;
            if (acc != 2'b00) begin
                if (req_valid == 2'b11) ep = 1 - model_last;
                else                    ep = req_valid[1] ? 1 : 0;
                n_tests++;
                if (acc !== (2'b01 << ep)) begin
                    n_fail++;
                    $display("FAIL grant: accepted=%b required=%b", acc, 2'b01 << ep);
                end
                n_tests++;
                if (outstanding) begin
                    n_fail++;
                    $display("FAIL overlap: accept while op outstanding=1, required 0");
                end
                e.port = ep;
                e.tag  = req_tag[TW*ep +: TW];
                e.err  = stub_dead;
                e.data = stub_dead ? 32'd0
                         : op_result(req_op[4*ep +: 4], req_a[32*ep +: 32], req_b[32*ep +: 32]);
                exp_q.push_back(e);
                model_last  = ep;
                outstanding = 1;
                n_accept++;
            end

            if (mds_in_valid) begin
                n_issue++;
                n_tests++;
                if (n_issue != n_accept) begin
                    n_fail++;
                    $display("FAIL issue_count: issues=%0d required=%0d", n_issue, n_accept);
                end
            end

            if (stub_busy) begin
                n_tests++;
                if (mds_in_a !== stub_a || mds_in_b !== stub_b || mds_op !== stub_op) begin
                    n_fail++;
                    $display("FAIL operand_hold: a=%h b=%h op=%h required a=%h b=%h op=%h",
                             mds_in_a, mds_in_b, mds_op, stub_a, stub_b, stub_op);
                end
            end

            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_rsp: port=%0d data=%h, required no response",
                                 p, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (p != e.port || rsp_tag !== e.tag || rsp_data !== e.data ||
                            rsp_err !== e.err) begin
                            n_fail++;
                            $display("FAIL rsp: port=%0d tag=%h data=%h err=%b required port=%0d tag=%h data=%h err=%b",
                                     p, rsp_tag, rsp_data, rsp_err, e.port, e.tag, e.data, e.err);
                        end
                    end
                    outstanding = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TW-1:0] tag);
        req_a[32*p +: 32]  = a;
        req_b[32*p +: 32]  = b;
        req_op[4*p +: 4]   = op;
        req_tag[TW*p +: TW] = tag;
        req_valid[p]       = 1'b1;
    endtask

    task automatic wait_rsp(input logic [1:0] mask, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            if ((rsp_valid & mask) != 2'b00) begin
                ok = 1;
                break;
            end
            step();
        end
        if ((rsp_valid & mask) != 2'b00) ok = 1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------- scenarios
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        n_tests++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'd0 || rsp_tag !== '0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b data=%h tag=%h err=%b required all zero",
                     rsp_valid, rsp_data, rsp_tag, rsp_err);
        end
        n_tests++;
        if (mds_in_valid !== 1'b0 || mds_in_a !== 32'd0 || mds_in_b !== 32'd0 ||
            mds_op !== 4'd0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mds: in_valid=%b a=%h b=%h op=%h ready=%b required all zero",
                     mds_in_valid, mds_in_a, mds_in_b, mds_op, req_ready);
        end
        reset = 1'b0;
        // Both asking straight out of reset: requester 0 goes first.
        req_valid = 2'b11;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: req_ready=%b required 01", req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        bit ok;
        stub_lat  = 3;
        rsp_ready = 2'b00;
        set_req(0, OP_SLL, 32'd1, 32'd4, 1'b1);
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: req_ready=%b required 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        n_tests++;
        if (mds_in_valid !== 1'b1 || mds_in_a !== 32'd1 || mds_in_b !== 32'd4 ||
            mds_op !== OP_SLL) begin
            n_fail++;
            $display("FAIL single_issue: in_valid=%b a=%h b=%h op=%h required 1 1 4 %h",
                     mds_in_valid, mds_in_a, mds_in_b, mds_op, OP_SLL);
        end
        step();
        n_tests++;
        if (mds_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse_width: in_valid=%b required 0", mds_in_valid);
        end
        rsp_ready = 2'b01;
        wait_rsp(2'b11, 50, ok);
        n_tests++;
        if (!ok || rsp_valid !== 2'b01 || rsp_data !== 32'd16 || rsp_err !== 1'b0 ||
            rsp_tag !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rsp: ok=%0d valid=%b data=%0d err=%b tag=%h required 1 01 16 0 1",
                     ok, rsp_valid, rsp_data, rsp_err, rsp_tag);
        end
        step();
        n_tests++;
        if (rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_rsp_clear: rsp_valid=%b required 00", rsp_valid);
        end
        rsp_ready = 2'b00;
    endtask

    task automatic test_round_robin();
        bit ok;
        int port;
        reset_dut();
        rsp_ready = 2'b11;
        set_req(0, OP_MUL, 32'd3, 32'd5, 1'b0);
        set_req(1, OP_MUL, 32'd7, 32'd6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_rsp(2'b11, 50, ok);
            port = rsp_valid[1] ? 1 : 0;
            n_tests++;
            if (!ok || port != i % 2 || rsp_data !== ((i % 2) ? 32'd42 : 32'd15)) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: ok=%0d port=%0d data=%0d required port=%0d data=%0d",
                         i, ok, port, rsp_data, i % 2, (i % 2) ? 42 : 15);
            end
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        rsp_ready = 2'b00;
        set_req(1, OP_DIV, 32'd100, 32'd7, 1'b1);
        step();
        req_valid[1] = 1'b0;
        set_req(0, OP_SLL, 32'd5, 32'd1, 1'b0);
        wait_rsp(2'b10, 50, ok);
        n_tests++;
        if (!ok || rsp_data !== 32'd14 || rsp_tag !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_rsp: ok=%0d data=%0d tag=%h required 1 14 1", ok, rsp_data, rsp_tag);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            rsp_ready = 2'b01;  // other requester's ready must not complete it
            step();
            if (rsp_valid !== 2'b10 || rsp_data !== 32'd14 || rsp_tag !== 1'b1 ||
                req_ready !== 2'b00) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        end
        rsp_ready = 2'b10;
        step();
        #1;
        n_tests++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b required 00 01",
                     rsp_valid, req_ready);
        end
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        wait_rsp(2'b01, 50, ok);
        n_tests++;
        if (!ok || rsp_data !== 32'd10) begin
            n_fail++;
            $display("FAIL bp_next: ok=%0d data=%0d required 1 10", ok, rsp_data);
        end
        step();
        rsp_ready = 2'b00;
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        int bad;
        stub_dead = 1'b1;
        rsp_ready = 2'b00;
        set_req(0, OP_MUL, 32'd9, 32'd9, 1'b0);
        step();
        req_valid = 2'b00;
        n_tests++;
        if (mds_in_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL to_issue: in_valid=%b required 1", mds_in_valid);
        end
        cnt = 0;
        while (rsp_valid[0] !== 1'b1 && cnt < TO + 20) begin
            step();
            cnt++;
        end
        // Response appears after the ISSUE cycle plus TIMEOUT_CYCLES cycles of waiting.
        n_tests++;
        if (cnt != TO + 1) begin
            n_fail++;
            $display("FAIL to_latency: %0d cycles after issue, required %0d", cnt, TO + 1);
        end
        n_tests++;
        if (rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL to_rsp: err=%b data=%h required 1 0", rsp_err, rsp_data);
        end
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        man_data  = 32'hdead_beef;
        man_pulse = 1'b1;
        step();
        man_pulse = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (rsp_valid !== 2'b00) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL to_stale: rsp_valid set %0d cycles after stale pulse, required 0", bad);
        end
        stub_dead = 1'b0;
        set_req(0, OP_SLL, 32'd3, 32'd2, 1'b1);
        step();
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        wait_rsp(2'b01, 50, ok);
        n_tests++;
        if (!ok || rsp_data !== 32'd12 || rsp_err !== 1'b0 || rsp_tag !== 1'b1) begin
            n_fail++;
            $display("FAIL to_recover: ok=%0d data=%0d err=%b tag=%h required 1 12 0 1",
                     ok, rsp_data, rsp_err, rsp_tag);
        end
        step();
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int bad;
        stub_lat = 20;
        set_req(1, OP_MUL, 32'd11, 32'd13, 1'b1);
        step();
        req_valid = 2'b00;
        repeat (3) step();
        reset = 1'b1;
        #1;
        n_tests++;
        if (rsp_valid !== 2'b00 || rsp_data !== 32'd0 || rsp_err !== 1'b0 || rsp_tag !== '0) begin
            n_fail++;
            $display("FAIL rst_async_rsp: valid=%b data=%h err=%b tag=%h required all zero",
                     rsp_valid, rsp_data, rsp_err, rsp_tag);
        end
        n_tests++;
        if (mds_in_a !== 32'd0 || mds_in_b !== 32'd0 || mds_op !== 4'd0 ||
            mds_in_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_mds: a=%h b=%h op=%h in_valid=%b required all zero",
                     mds_in_a, mds_in_b, mds_op, mds_in_valid);
        end
        step();
        step();
        reset     = 1'b0;
        rsp_ready = 2'b11;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (rsp_valid !== 2'b00) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_abandon: response seen %0d cycles, required 0", bad);
        end
        stub_lat = 3;
        set_req(0, OP_SLL, 32'd1, 32'd1, 1'b0);
        set_req(1, OP_SRL, 32'h80, 32'd3, 1'b1);
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_first: req_ready=%b required 01", req_ready);
        end
        step();
        req_valid[0] = 1'b0;
        wait_rsp(2'b01, 50, ok);
        n_tests++;
        if (!ok || rsp_data !== 32'd2) begin
            n_fail++;
            $display("FAIL rst_op0: ok=%0d data=%0d required 1 2", ok, rsp_data);
        end
        step();
        wait_rsp(2'b10, 50, ok);
        req_valid = 2'b00;
        n_tests++;
        if (!ok || rsp_data !== 32'h10) begin
            n_fail++;
            $display("FAIL rst_op1: ok=%0d data=%h required 1 10", ok, rsp_data);
        end
        step();
        rsp_ready = 2'b00;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step();
            stub_lat  = $urandom_range(0, 6);
            rsp_ready = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                if (last_acc[p]) req_valid[p] = 1'b0;
                if (!req_valid[p] && $urandom_range(0, 2) == 0) begin
                    set_req(p, 4'($urandom_range(1, 6)), $urandom, $urandom,
                            TW'($urandom_range(0, 1)));
                end
            end
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (40) step();
        n_tests++;
        if (exp_q.size() != 0 || n_issue != n_accept) begin
            n_fail++;
            $display("FAIL random_drain: pending=%0d issues=%0d accepts=%0d required 0 and equal",
                     exp_q.size(), n_issue, n_accept);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        n_accept    = 0;
        n_issue     = 0;
        model_last  = 1;
        outstanding = 0;
        last_acc    = 2'b00;
        reset       = 1'b1;
        req_valid   = 2'b00;
        req_a       = '0;
        req_b       = '0;
        req_op      = '0;
        req_tag     = '0;
        rsp_ready   = 2'b00;
        stub_dead   = 1'b0;
        stub_lat    = 3;
        man_pulse   = 1'b0;
        man_data    = '0;

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_op();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
